// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter that shares both ports of the 8x128 dual-port RAM among NREQ requesters.
// Issues up to two non-conflicting accesses per cycle and routes read data back by requester id.
module dpram_port_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned AW   = 3,
   parameter int unsigned DW   = 128
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NREQ-1:0]    i_req_valid,
   input  logic [NREQ-1:0]    i_req_we,
   input  logic [NREQ*AW-1:0] i_req_addr,
   input  logic [NREQ*DW-1:0] i_req_wdata,
   output logic [NREQ-1:0]    o_req_ready,
   output logic [NREQ-1:0]    o_rsp_valid,
   output logic [NREQ*DW-1:0] o_rsp_rdata,
   output logic               o_ram_wr_en_a,
   output logic [AW-1:0]      o_ram_addr_a,
   output logic [DW-1:0]      o_ram_data_a,
   input  logic [DW-1:0]      i_ram_q_a,
   output logic               o_ram_wr_en_b,
   output logic [AW-1:0]      o_ram_addr_b,
   output logic [DW-1:0]      o_ram_data_b,
   input  logic [DW-1:0]      i_ram_q_b
);

   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IDW-1:0] LastId = IDW'(NREQ - 1);

   logic [AW-1:0]  w_addr  [NREQ];
   logic [DW-1:0]  w_wdata [NREQ];

   logic [IDW-1:0] r_rr_ptr;
   logic           r_wr_en_a, r_wr_en_b;
   logic [AW-1:0]  r_addr_a, r_addr_b;
   logic [DW-1:0]  r_data_a, r_data_b;
   // Stage 1 tags follow the command on ram_*, stage 2 tags line up with ram_q.
   logic           r_tag1_a_vld, r_tag1_b_vld, r_tag2_a_vld, r_tag2_b_vld;
   logic [IDW-1:0] r_tag1_a_id, r_tag1_b_id, r_tag2_a_id, r_tag2_b_id;

   logic           w_a_vld, w_b_vld;
   logic [IDW-1:0] w_a_id, w_b_id, w_idx, w_last, w_rr_nxt;
   logic [NREQ-1:0] w_ready;

   always_comb begin
      for (int i = 0; i < int'(NREQ); i++) begin
         w_addr[i]  = i_req_addr[i*AW +: AW];
         w_wdata[i] = i_req_wdata[i*DW +: DW];
      end
   end

   // Scan from r_rr_ptr; a candidate that conflicts with port A is skipped, not blocking.
   always_comb begin
      w_a_vld = 1'b0;
      w_b_vld = 1'b0;
      w_a_id  = '0;
      w_b_id  = '0;
      w_idx   = r_rr_ptr;
      w_ready = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         if (!i_rst && i_req_valid[w_idx]) begin
            if (!w_a_vld) begin
               w_a_vld = 1'b1;
               w_a_id  = w_idx;
            end else if (!w_b_vld &&
                         !((w_addr[w_idx] == w_addr[w_a_id]) &&
                           (i_req_we[w_idx] || i_req_we[w_a_id]))) begin
               w_b_vld = 1'b1;
               w_b_id  = w_idx;
            end
         end
         w_idx = (w_idx == LastId) ? '0 : w_idx + 1'b1;
      end
      if (w_a_vld) w_ready[w_a_id] = 1'b1;
      if (w_b_vld) w_ready[w_b_id] = 1'b1;
      w_last   = w_b_vld ? w_b_id : w_a_id;
      w_rr_nxt = (w_last == LastId) ? '0 : w_last + 1'b1;
   end

   assign o_req_ready = w_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rr_ptr     <= '0;
         r_wr_en_a    <= 1'b0;
         r_addr_a     <= '0;
         r_data_a     <= '0;
         r_wr_en_b    <= 1'b0;
         r_addr_b     <= '0;
         r_data_b     <= '0;
         r_tag1_a_vld <= 1'b0;
         r_tag1_a_id  <= '0;
         r_tag1_b_vld <= 1'b0;
         r_tag1_b_id  <= '0;
         r_tag2_a_vld <= 1'b0;
         r_tag2_a_id  <= '0;
         r_tag2_b_vld <= 1'b0;
         r_tag2_b_id  <= '0;
      end else begin
         if (w_a_vld) r_rr_ptr <= w_rr_nxt;
         // An ungranted port issues a dummy read of address 0; its tag stays invalid.
         r_wr_en_a    <= w_a_vld && i_req_we[w_a_id];
         r_addr_a     <= w_a_vld ? w_addr[w_a_id] : '0;
         r_data_a     <= w_a_vld ? w_wdata[w_a_id] : '0;
         r_wr_en_b    <= w_b_vld && i_req_we[w_b_id];
         r_addr_b     <= w_b_vld ? w_addr[w_b_id] : '0;
         r_data_b     <= w_b_vld ? w_wdata[w_b_id] : '0;
         r_tag1_a_vld <= w_a_vld && !i_req_we[w_a_id];
         r_tag1_a_id  <= w_a_id;
         r_tag1_b_vld <= w_b_vld && !i_req_we[w_b_id];
         r_tag1_b_id  <= w_b_id;
         r_tag2_a_vld <= r_tag1_a_vld;
         r_tag2_a_id  <= r_tag1_a_id;
         r_tag2_b_vld <= r_tag1_b_vld;
         r_tag2_b_id  <= r_tag1_b_id;
      end
   end

   assign o_ram_wr_en_a = r_wr_en_a;
   assign o_ram_addr_a  = r_addr_a;
   assign o_ram_data_a  = r_data_a;
   assign o_ram_wr_en_b = r_wr_en_b;
   assign o_ram_addr_b  = r_addr_b;
   assign o_ram_data_b  = r_data_b;

   always_comb begin
      o_rsp_valid = '0;
      o_rsp_rdata = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (r_tag2_a_vld && (r_tag2_a_id == IDW'(i))) begin
            o_rsp_valid[i]           = 1'b1;
            o_rsp_rdata[i*DW +: DW]  = i_ram_q_a;
         end
         if (r_tag2_b_vld && (r_tag2_b_id == IDW'(i))) begin
            o_rsp_valid[i]           = 1'b1;
            o_rsp_rdata[i*DW +: DW]  = i_ram_q_b;
         end
      end
   end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed self-checking bench for dpram_port_arbiter with a behavioural 8x128 registered-read RAM.
module tb_dpram_port_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 3;
   localparam int DW   = 128;

   logic               clk;
   logic               rst;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_we;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    rsp_valid;
   logic [NREQ*DW-1:0] rsp_rdata;
   logic               ram_wr_en_a, ram_wr_en_b;
   logic [AW-1:0]      ram_addr_a, ram_addr_b;
   logic [DW-1:0]      ram_data_a, ram_data_b;
   logic [DW-1:0]      ram_q_a, ram_q_b;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem [8];

   dpram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_req_valid   (req_valid),
      .i_req_we      (req_we),
      .i_req_addr    (req_addr),
      .i_req_wdata   (req_wdata),
      .o_req_ready   (req_ready),
      .o_rsp_valid   (rsp_valid),
      .o_rsp_rdata   (rsp_rdata),
      .o_ram_wr_en_a (ram_wr_en_a),
      .o_ram_addr_a  (ram_addr_a),
      .o_ram_data_a  (ram_data_a),
      .i_ram_q_a     (ram_q_a),
      .o_ram_wr_en_b (ram_wr_en_b),
      .o_ram_addr_b  (ram_addr_b),
      .o_ram_data_b  (ram_data_b),
      .i_ram_q_b     (ram_q_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_wr_en_a) mem[ram_addr_a] <= ram_data_a;
      if (ram_wr_en_b) mem[ram_addr_b] <= ram_data_b;
      ram_q_a <= mem[ram_addr_a];
      ram_q_b <= mem[ram_addr_b];
   end

   function automatic logic [DW-1:0] pat(input logic [7:0] b);
      return {16{b}};
   endfunction

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      req_we[i]             = we;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic next_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_we    = '0;
      next_drive();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = '1;
      req_we    = '1;
      req_addr  = '0;
      req_wdata = '0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         @(negedge clk);
         checks += 4;
         if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready: got %b want 0000", req_ready);
         end
         if (ram_wr_en_a !== 1'b0) begin
            errors++; $display("FAIL reset_wr_en_a: got %b want 0", ram_wr_en_a);
         end
         if (ram_wr_en_b !== 1'b0) begin
            errors++; $display("FAIL reset_wr_en_b: got %b want 0", ram_wr_en_b);
         end
         if (rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid);
         end
      end
      next_drive();
      rst       = 1'b0;
      req_valid = '0;
      req_we    = '0;
   endtask

   task automatic test_write_read();
      do_reset();
      set_req(0, 1'b1, 3'd3, pat(8'hA5));
      req_valid = 4'b0001;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL wr_ready: got %b want 0001", req_ready);
      end
      next_drive();
      set_req(0, 1'b0, 3'd3, '0);
      @(negedge clk);
      checks += 4;
      if (ram_wr_en_a !== 1'b1) begin
         errors++; $display("FAIL wr_en_a: got %b want 1", ram_wr_en_a);
      end
      if (ram_addr_a !== 3'd3) begin
         errors++; $display("FAIL wr_addr_a: got %0d want 3", ram_addr_a);
      end
      if (ram_data_a !== pat(8'hA5)) begin
         errors++; $display("FAIL wr_data_a: got %h want %h", ram_data_a, pat(8'hA5));
      end
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL rd_ready: got %b want 0001", req_ready);
      end
      next_drive();
      req_valid = '0;
      @(negedge clk);
      checks += 3;
      if (ram_wr_en_a !== 1'b0 || ram_addr_a !== 3'd3) begin
         errors++; $display("FAIL rd_cmd_a: got we=%b addr=%0d want we=0 addr=3",
                            ram_wr_en_a, ram_addr_a);
      end
      if (rsp_valid !== 4'b0000) begin
         errors++; $display("FAIL rd_early_rsp: got %b want 0000", rsp_valid);
      end
      if (ram_wr_en_b !== 1'b0 || ram_addr_b !== 3'd0) begin
         errors++; $display("FAIL rd_idle_b: got we=%b addr=%0d want 0/0",
                            ram_wr_en_b, ram_addr_b);
      end
      @(posedge clk);
      @(negedge clk);
      checks += 2;
      if (rsp_valid !== 4'b0001) begin
         errors++; $display("FAIL rd_rsp_valid: got %b want 0001", rsp_valid);
      end
      if (rsp_rdata[0 +: DW] !== pat(8'hA5)) begin
         errors++; $display("FAIL rd_rsp_data: got %h want %h", rsp_rdata[0 +: DW], pat(8'hA5));
      end
      next_drive();
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         mem[i] <= pat(8'(8'h10 + i));
         set_req(i, 1'b0, 3'(i), '0);
      end
      req_valid = 4'b1111;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0011) begin
         errors++; $display("FAIL rr_c1_ready: got %b want 0011", req_ready);
      end
      next_drive();
      @(negedge clk);
      checks += 2;
      if (req_ready !== 4'b1100) begin
         errors++; $display("FAIL rr_c2_ready: got %b want 1100", req_ready);
      end
      if (ram_addr_a !== 3'd0 || ram_addr_b !== 3'd1 || ram_wr_en_a !== 1'b0
          || ram_wr_en_b !== 1'b0) begin
         errors++; $display("FAIL rr_c2_cmd: got a=%0d b=%0d we=%b%b want a=0 b=1 we=00",
                            ram_addr_a, ram_addr_b, ram_wr_en_a, ram_wr_en_b);
      end
      next_drive();
      @(negedge clk);
      checks += 6;
      if (req_ready !== 4'b0011) begin
         errors++; $display("FAIL rr_c3_ready: got %b want 0011", req_ready);
      end
      if (ram_addr_a !== 3'd2 || ram_addr_b !== 3'd3) begin
         errors++; $display("FAIL rr_c3_cmd: got a=%0d b=%0d want a=2 b=3",
                            ram_addr_a, ram_addr_b);
      end
      if (rsp_valid !== 4'b0011) begin
         errors++; $display("FAIL rr_c3_rsp_valid: got %b want 0011", rsp_valid);
      end
      if (rsp_rdata[0 +: DW] !== pat(8'h10)) begin
         errors++; $display("FAIL rr_c3_rdata0: got %h want %h", rsp_rdata[0 +: DW], pat(8'h10));
      end
      if (rsp_rdata[DW +: DW] !== pat(8'h11)) begin
         errors++; $display("FAIL rr_c3_rdata1: got %h want %h", rsp_rdata[DW +: DW], pat(8'h11));
      end
      if (rsp_rdata[2*DW +: DW] !== '0) begin
         errors++; $display("FAIL rr_c3_rdata2_idle: got %h want 0", rsp_rdata[2*DW +: DW]);
      end
      next_drive();
      req_valid = '0;
      @(negedge clk);
      checks += 3;
      if (rsp_valid !== 4'b1100) begin
         errors++; $display("FAIL rr_c4_rsp_valid: got %b want 1100", rsp_valid);
      end
      if (rsp_rdata[2*DW +: DW] !== pat(8'h12)) begin
         errors++; $display("FAIL rr_c4_rdata2: got %h want %h", rsp_rdata[2*DW +: DW], pat(8'h12));
      end
      if (rsp_rdata[3*DW +: DW] !== pat(8'h13)) begin
         errors++; $display("FAIL rr_c4_rdata3: got %h want %h", rsp_rdata[3*DW +: DW], pat(8'h13));
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0011) begin
         errors++; $display("FAIL rr_c5_rsp_valid: got %b want 0011", rsp_valid);
      end
      next_drive();
   endtask

   task automatic test_conflict_ww();
      do_reset();
      set_req(1, 1'b1, 3'd5, pat(8'h11));
      set_req(2, 1'b1, 3'd5, pat(8'h22));
      req_valid = 4'b0110;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++; $display("FAIL ww_c1_ready: got %b want 0010", req_ready);
      end
      next_drive();
      req_valid = 4'b0100;
      @(negedge clk);
      checks += 3;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL ww_c2_ready: got %b want 0100", req_ready);
      end
      if (ram_wr_en_a !== 1'b1 || ram_addr_a !== 3'd5 || ram_data_a !== pat(8'h11)) begin
         errors++; $display("FAIL ww_c2_cmd_a: got we=%b addr=%0d data=%h want 1/5/%h",
                            ram_wr_en_a, ram_addr_a, ram_data_a, pat(8'h11));
      end
      if (ram_wr_en_b !== 1'b0 || ram_addr_b !== 3'd0 || ram_data_b !== '0) begin
         errors++; $display("FAIL ww_c2_idle_b: got we=%b addr=%0d data=%h want 0/0/0",
                            ram_wr_en_b, ram_addr_b, ram_data_b);
      end
      next_drive();
      req_valid = 4'b0001;
      set_req(0, 1'b0, 3'd5, '0);
      @(negedge clk);
      checks += 2;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL ww_c3_ready: got %b want 0001", req_ready);
      end
      if (ram_wr_en_a !== 1'b1 || ram_data_a !== pat(8'h22)) begin
         errors++; $display("FAIL ww_c3_cmd_a: got we=%b data=%h want 1/%h",
                            ram_wr_en_a, ram_data_a, pat(8'h22));
      end
      next_drive();
      req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      checks += 2;
      if (rsp_valid !== 4'b0001) begin
         errors++; $display("FAIL ww_rsp_valid: got %b want 0001", rsp_valid);
      end
      if (rsp_rdata[0 +: DW] !== pat(8'h22)) begin
         errors++; $display("FAIL ww_rsp_data: got %h want %h", rsp_rdata[0 +: DW], pat(8'h22));
      end
      next_drive();
   endtask

   task automatic test_conflict_rw();
      do_reset();
      mem[2] <= pat(8'h33);
      mem[6] <= pat(8'h66);
      set_req(0, 1'b0, 3'd2, '0);
      set_req(1, 1'b1, 3'd2, pat(8'h44));
      set_req(3, 1'b0, 3'd6, '0);
      req_valid = 4'b1011;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b1001) begin
         errors++; $display("FAIL rw_c1_ready: got %b want 1001", req_ready);
      end
      next_drive();
      req_valid = 4'b0010;
      @(negedge clk);
      checks += 2;
      if (req_ready !== 4'b0010) begin
         errors++; $display("FAIL rw_c2_ready: got %b want 0010", req_ready);
      end
      if (ram_addr_a !== 3'd2 || ram_addr_b !== 3'd6 || ram_wr_en_a !== 1'b0
          || ram_wr_en_b !== 1'b0) begin
         errors++; $display("FAIL rw_c2_cmd: got a=%0d b=%0d we=%b%b want a=2 b=6 we=00",
                            ram_addr_a, ram_addr_b, ram_wr_en_a, ram_wr_en_b);
      end
      next_drive();
      req_valid = '0;
      @(negedge clk);
      checks += 4;
      if (rsp_valid !== 4'b1001) begin
         errors++; $display("FAIL rw_rsp_valid: got %b want 1001", rsp_valid);
      end
      if (rsp_rdata[0 +: DW] !== pat(8'h33)) begin
         errors++; $display("FAIL rw_rdata0: got %h want %h", rsp_rdata[0 +: DW], pat(8'h33));
      end
      if (rsp_rdata[3*DW +: DW] !== pat(8'h66)) begin
         errors++; $display("FAIL rw_rdata3: got %h want %h", rsp_rdata[3*DW +: DW], pat(8'h66));
      end
      if (ram_wr_en_a !== 1'b1 || ram_addr_a !== 3'd2 || ram_data_a !== pat(8'h44)) begin
         errors++; $display("FAIL rw_c3_cmd_a: got we=%b addr=%0d data=%h want 1/2/%h",
                            ram_wr_en_a, ram_addr_a, ram_data_a, pat(8'h44));
      end
      next_drive();
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_req(2, 1'b0, 3'd1, '0);
      req_valid = 4'b0100;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL mid_c0_ready: got %b want 0100", req_ready);
      end
      next_drive();
      rst       = 1'b1;
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0000) begin
         errors++; $display("FAIL mid_c1_rsp: got %b want 0000", rsp_valid);
      end
      next_drive();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0000) begin
         errors++; $display("FAIL mid_c2_rsp: got %b want 0000", rsp_valid);
      end
      next_drive();
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0000) begin
         errors++; $display("FAIL mid_c3_rsp: got %b want 0000", rsp_valid);
      end
      next_drive();
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 3'(i), '0);
      req_valid = 4'b1111;
      @(negedge clk);
      checks++;
      // A pointer left at 3 by the req2 grant would give 1001 here.
      if (req_ready !== 4'b0011) begin
         errors++; $display("FAIL mid_rr_ptr: got %b want 0011", req_ready);
      end
      next_drive();
      req_valid = '0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
      test_reset();
      test_write_read();
      test_round_robin();
      test_conflict_ww();
      test_conflict_rw();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
